// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module      : pc_sequencer_if
// Description : Decode/branch-resolve and fetch-side bundle for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if;
    logic        fetch_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        redirect;
    logic        addr_err;

    modport master (
        output fetch_ready, stall, branch_taken, branch_offset,
               jump, jump_index, jump_reg, jr_target,
        input  pc, pc_plus4, pc_valid, redirect, addr_err
    );

    modport slave (
        input  fetch_ready, stall, branch_taken, branch_offset,
               jump, jump_index, jump_reg, jr_target,
        output pc, pc_plus4, pc_valid, redirect, addr_err
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : MIPS program counter owner; picks the next fetch address and
//               holds redirects that arrive while fetch is stalled.
//               Optional macro ALIGN_CHECK_EN traps misaligned JR targets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  wire logic    clk,
    input  wire logic    reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        pend_err_q, pend_err_d;
    logic        valid_q, valid_d;
    logic        redirect_q, redirect_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_plus4;
    logic        advance;
    logic        request;
    logic        jr_misaligned;
    logic [31:0] target;
    logic        target_err;
    logic        unused_offset_bits;

    assign pc_plus4 = pc_q + 32'd4;
    assign advance  = valid_q & bus.fetch_ready & ~bus.stall;
    assign request  = bus.jump_reg | bus.jump | bus.branch_taken;

    // Offset is a word count, so its top two bits shift out of the byte address.
    assign unused_offset_bits = ^bus.branch_offset[31:30];

`ifdef ALIGN_CHECK_EN
    assign jr_misaligned = bus.jump_reg & (bus.jr_target[1:0] != 2'b00);
`else
    assign jr_misaligned = 1'b0;
`endif

    always_comb begin
        target     = pc_plus4;
        target_err = 1'b0;
        if (bus.jump_reg) begin
            target     = jr_misaligned ? EXC_VECTOR : bus.jr_target;
            target_err = jr_misaligned;
        end else if (bus.jump) begin
            target = {pc_plus4[31:28], bus.jump_index, 2'b00};
        end else if (bus.branch_taken) begin
            target = pc_plus4 + {bus.branch_offset[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        pend_err_d = pend_err_q;
        valid_d    = valid_q;
        redirect_d = 1'b0;
        addr_err_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (advance) begin
                    pc_d       = request ? target : pc_plus4;
                    redirect_d = request;
                    addr_err_d = request & target_err;
                end else if (request) begin
                    pending_d  = target;
                    pend_err_d = target_err;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The first latched redirect wins; new requests are ignored here.
                if (advance) begin
                    pc_d       = pending_q;
                    redirect_d = 1'b1;
                    addr_err_d = pend_err_q;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pending_q  <= 32'h0000_0000;
            pend_err_q <= 1'b0;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            pend_err_q <= pend_err_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.pc_valid = valid_q;
    assign bus.redirect = redirect_q;
    assign bus.addr_err = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed plus random checks of pc_sequencer against a
//               queue-based reference model (honours ALIGN_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] C_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] C_EXC_VECTOR = 32'h0000_0180;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_boot;
    bit          m_redirect;
    bit          m_err;
    logic [32:0] m_pend[$];

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (C_RESET_PC),
        .EXC_VECTOR (C_EXC_VECTOR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {error_flag, address} for the highest-priority request.
    function automatic logic [32:0] spec_target(input logic [31:0] pc);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (bus.jump_reg) begin
`ifdef ALIGN_CHECK_EN
            if (bus.jr_target[1:0] != 2'b00) return {1'b1, C_EXC_VECTOR};
`endif
            return {1'b0, bus.jr_target};
        end
        if (bus.jump)
            return {1'b0, p4[31:28], bus.jump_index, 2'b00};
        if (bus.branch_taken)
            return {1'b0, p4 + (bus.branch_offset << 2)};
        return {1'b0, p4};
    endfunction

    task automatic model_edge();
        bit          adv;
        bit          req;
        logic [32:0] t;
        if (reset) begin
            m_pc = C_RESET_PC; m_valid = 0; m_boot = 1;
            m_redirect = 0; m_err = 0; m_pend.delete();
            return;
        end
        adv = m_valid && bus.fetch_ready && !bus.stall;
        req = bus.jump_reg || bus.jump || bus.branch_taken;
        m_redirect = 0;
        m_err      = 0;
        if (m_boot) begin
            m_boot  = 0;
            m_valid = 1;
        end else if (m_pend.size() != 0) begin
            if (adv) begin
                t = m_pend.pop_front();
                m_pc = t[31:0]; m_redirect = 1; m_err = t[32];
            end
        end else begin
            t = spec_target(m_pc);
            if (adv) begin
                m_pc = t[31:0];
                m_redirect = req;
                m_err = req && t[32];
            end else if (req) begin
                m_pend.push_back(t);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("pc",       bus.pc,                 m_pc);
        check("pc_plus4", bus.pc_plus4,           m_pc + 32'd4);
        check("pc_valid", {31'b0, bus.pc_valid},  {31'b0, m_valid});
        check("redirect", {31'b0, bus.redirect},  {31'b0, m_redirect});
        check("addr_err", {31'b0, bus.addr_err},  {31'b0, m_err});
    endtask

    task automatic idle();
        bus.fetch_ready = 1; bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = '0;
        bus.jump = 0; bus.jump_index = '0; bus.jump_reg = 0; bus.jr_target = '0;
    endtask

    task automatic do_jr(input logic [31:0] tgt);
        idle(); bus.jump_reg = 1; bus.jr_target = tgt;
        tick();
        idle();
    endtask

    initial begin
        logic [31:0] r;
        reset = 1;
        idle();
        tick(); tick();
        check("reset_pc", bus.pc, 32'h0);
        check("reset_valid", {31'b0, bus.pc_valid}, 32'h0);
        reset = 0;
        tick();
        check("boot_done_valid", {31'b0, bus.pc_valid}, 32'h1);
        check("boot_pc", bus.pc, 32'h0);
        tick(); check("seq1", bus.pc, 32'h4);
        tick(); check("seq2", bus.pc, 32'h8);
        tick(); check("seq3", bus.pc, 32'hC);

        do_jr(32'hB000_0040);
        bus.jump = 1; bus.jump_index = 26'h2AA_AAAA;
        tick(); check("j_target", bus.pc, 32'hBAAA_AAA8);
        check("j_redirect", {31'b0, bus.redirect}, 32'h1);
        idle(); tick();
        check("redirect_one_cycle", {31'b0, bus.redirect}, 32'h0);

        do_jr(32'h0FFF_FFFC);
        bus.jump = 1; bus.jump_index = 26'h000_0010;
        tick(); check("j_region", bus.pc, 32'h1000_0040);

        do_jr(32'h0000_0100);
        bus.branch_taken = 1; bus.branch_offset = 32'hFFFF_FFFE;
        tick(); check("branch_back", bus.pc, 32'h0000_00FC);
        do_jr(32'h0000_0100);
        bus.branch_taken = 1; bus.branch_offset = 32'hFFFF_FFFE;
        bus.jump = 1; bus.jump_index = 26'h000_0400;
        tick(); check("jump_over_branch", bus.pc, 32'h0000_1000);

        idle(); bus.fetch_ready = 0; bus.jump_reg = 1; bus.jr_target = 32'h0040_0020;
        tick();
        idle(); bus.fetch_ready = 0; bus.jump = 1; bus.jump_index = 26'h123_4567;
        tick(); tick(); tick();
        check("hold_pc", bus.pc, 32'h0000_1000);
        idle(); tick();
        check("hold_release", bus.pc, 32'h0040_0020);

        idle(); bus.fetch_ready = 0; bus.jump = 1; bus.jump_index = 26'h000_0005;
        tick();
        idle(); bus.fetch_ready = 0; reset = 1;
        tick();
        reset = 0; bus.fetch_ready = 1;
        tick(); tick();
        check("reset_drops_pending", bus.pc, 32'h4);

        do_jr(32'h0040_0022);
`ifdef ALIGN_CHECK_EN
        check("misaligned_jr", bus.pc, 32'h0000_0180);
        check("addr_err_pulse", {31'b0, bus.addr_err}, 32'h1);
`else
        check("misaligned_jr", bus.pc, 32'h0040_0022);
        check("addr_err_tied", {31'b0, bus.addr_err}, 32'h0);
`endif
        idle(); bus.fetch_ready = 0; bus.jump_reg = 1; bus.jr_target = 32'h0040_0021;
        tick();
        idle(); tick();

        do_jr(32'hFFFF_FFFC);
        tick(); check("wrap", bus.pc, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            reset              = ($urandom_range(0, 59) == 0);
            bus.fetch_ready    = ($urandom_range(0, 3) != 0);
            bus.stall          = ($urandom_range(0, 4) == 0);
            bus.jump_reg       = ($urandom_range(0, 7) == 0);
            bus.jump           = ($urandom_range(0, 5) == 0);
            bus.branch_taken   = ($urandom_range(0, 4) == 0);
            r                  = $urandom;
            bus.branch_offset  = {{16{r[15]}}, r[15:0]};
            bus.jump_index     = 26'($urandom);
            r                  = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            bus.jr_target      = r;
            tick();
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter register of the single-issue MIPS core and decides the next fetch address every cycle. It forms the jump target by joining the upper nibble of PC+4 with the 26-bit jump index shifted left by two. It also forms branch and jump-register targets, and holds redirects that arrive while fetch is stalled. It sits between the decode/branch-resolve logic and the instruction memory port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0180, redirect address on a misaligned jump-register target (used only with ALIGN_CHECK_EN)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high
fetch_ready  input  1  instruction memory accepts the current pc this cycle
stall  input  1  hazard unit freezes the PC
branch_taken  input  1  conditional branch resolved taken
branch_offset  input  32  sign-extended 16-bit immediate, word units
jump  input  1  J/JAL decoded
jump_index  input  26  instr[25:0]
jump_reg  input  1  JR/JALR decoded
jr_target  input  32  register-file value for JR
pc  output  32  current fetch address
pc_plus4  output  32  pc + 4, combinational from pc
pc_valid  output  1  pc is a valid fetch request
redirect  output  1  one-cycle pulse when a non-sequential PC is loaded; used to flush IF/ID
addr_err  output  1  misaligned JR target flag (only with ALIGN_CHECK_EN)

Behaviour:
- Reset (synchronous): pc=RESET_PC, pc_valid=0, redirect=0, addr_err=0, pending cleared, state=BOOT.
- States:
  - BOOT: lasts one cycle after reset deasserts; pc_valid=0; then goes to RUN.
  - RUN: pc_valid=1.
  - HOLD: a redirect is pending; pc_valid=1 and pc is unchanged.
- advance = pc_valid & fetch_ready & ~stall.
- Target selection, fixed priority jump_reg > jump > branch_taken > sequential:
  - JR target = jr_target.
  - J target = {pc_plus4[31:28], jump_index, 2'b00}.
  - Branch target = pc_plus4 + {branch_offset[29:0], 2'b00}, modulo 2^32.
  - Sequential = pc_plus4, wrapping 0xFFFF_FFFC to 0x0000_0000.
- Lower-priority requests in the same cycle are dropped. They are not queued.
- RUN with advance: pc <= selected target on the next edge. redirect=1 for that one cycle if the target is non-sequential.
- RUN without advance but a redirect request present: latch the target into pending_pc and go to HOLD. pc is unchanged.
- HOLD: new jump/branch/jump_reg inputs are ignored; the first latched redirect wins. On the first advance: pc <= pending_pc, redirect pulses, go to RUN.
- Plain stall or no fetch_ready with no request: pc holds and no state change.
- Latency: one cycle from request (with advance) to new pc.
- Reset asserted in any state, including HOLD, discards the pending redirect.
- The pc register is fully registered. pc_plus4 is the only combinational output.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - A selected JR target with jr_target[1:0]!=0 loads EXC_VECTOR instead of the target.
  - addr_err=1 for one cycle, coincident with redirect.
  - The same check applies when the target is latched into HOLD; addr_err pulses when the pending redirect is applied.
- Undefined:
  - jr_target is used as-is (low bits are passed through).
  - addr_err is tied to 0.

Test Plan:
- Reset with RESET_PC=0 -> pc=0, pc_valid=0 for one cycle, then 1; sequential advances give 0x4, 0x8, 0xC.
- pc=0xB000_0040, jump=1, jump_index=0x2AA_AAAA -> next pc=0xBAAA_AAA8, redirect pulses for 1 cycle.
- Region boundary: pc=0x0FFF_FFFC, jump=1, jump_index=0x000_0010 -> pc=0x1000_0040 (nibble taken from PC+4).
- pc=0x0000_0100, branch_taken=1, branch_offset=0xFFFF_FFFE -> pc=0x0000_00FC. With jump and branch in the same cycle, the jump wins.
- Redirect under fetch_ready=0: jump_reg=1, jr_target=0x0040_0020; hold fetch_ready=0 for 3 cycles with a different jump in between -> pc unchanged; on ready, pc=0x0040_0020. Reset during HOLD -> pc=RESET_PC and no pending redirect.
- With ALIGN_CHECK_EN: jr_target=0x0040_0022 -> pc=0x0000_0180, addr_err=1 for 1 cycle. Wrap check: pc=0xFFFF_FFFC sequential -> 0x0000_0000.
